// File: rtl/ysyx_24110026_ifu_pkg.sv
// IFU shared constants: FSM state encodings and reset PC.
// Imported by the IFU top and its timeout counter.
package ysyx_24110026_ifu_pkg;

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

  function automatic logic [31:0] seq_pc(
    input logic [31:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/ysyx_24110026_ifu_timeout.sv
// Fetch wait counter: cleared on request accept, counts while waiting,
// expire is high once TIMEOUT_CYCLES waiting cycles have elapsed.
module ysyx_24110026_ifu_timeout
  import ysyx_24110026_ifu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expire
);

  localparam int unsigned W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign expire = (cnt_q == LAST);

  // Saturate at LAST so the count never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && !expire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ysyx_24110026_ifu.sv
// Instruction fetch unit: PC, imem request/response, decode handoff.
// Define IFU_MISALIGN_CHECK_EN to trap misaligned redirect targets.
module ysyx_24110026_ifu
  import ysyx_24110026_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = IFU_RESET_PC,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        fetch_err,
  output logic        misalign_err
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        drop_q, drop_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        ferr_q, ferr_d;
  logic        req_hs;
  logic        tmo_clear;
  logic        tmo_en;
  logic        tmo_expire;
  logic        redir_bad;
  logic [31:0] redir_pc;

`ifdef IFU_MISALIGN_CHECK_EN
  logic mis_q, mis_d;
  assign redir_bad    = (redirect_pc[1:0] != 2'b00);
  assign redir_pc     = redirect_pc;
  assign misalign_err = mis_q;
`else
  logic unused_redir_lsb;
  assign unused_redir_lsb = ^redirect_pc[1:0];
  assign redir_bad    = 1'b0;
  assign redir_pc     = {redirect_pc[31:2], 2'b00};
  assign misalign_err = 1'b0;
`endif

  assign req_hs         = (state_q == S_REQ) && imem_req_ready;
  assign tmo_clear      = req_hs;
  assign tmo_en         = (state_q == S_WAIT);
  assign imem_req_valid = (state_q == S_REQ);
  assign imem_req_addr  = pc_q;
  assign inst_valid     = (state_q == S_OUT);
  assign inst           = inst_q;
  assign inst_pc        = inst_pc_q;
  assign fetch_err      = ferr_q;

  ysyx_24110026_ifu_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clear (tmo_clear),
    .en    (tmo_en),
    .expire(tmo_expire)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    ferr_d    = ferr_q;
`ifdef IFU_MISALIGN_CHECK_EN
    mis_d     = 1'b0;
`endif
    unique case (state_q)
      S_REQ: begin
        if (req_hs) begin
          state_d  = S_WAIT;
          req_pc_d = pc_q;
          drop_d   = 1'b0;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            inst_d    = imem_resp_data;
            inst_pc_d = req_pc_q;
            pc_d      = seq_pc(req_pc_q);
            state_d   = S_OUT;
          end
        end else if (tmo_expire) begin
          state_d = S_ERR;
          ferr_d  = 1'b1;
        end
      end
      S_OUT: begin
        if (inst_ready) begin
          state_d = S_REQ;
        end
      end
      default: ;
    endcase
    // Redirect overrides the sequential update; a same-cycle
    // response is discarded rather than handed to decode.
    if (redirect_valid && state_q != S_ERR) begin
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      if (redir_bad) begin
`ifdef IFU_MISALIGN_CHECK_EN
        mis_d = 1'b1;
`endif
        pc_d    = pc_q;
        state_d = S_ERR;
      end else begin
        pc_d = redir_pc;
        if (state_q == S_REQ) begin
          drop_d = req_hs;
        end else if (state_q == S_WAIT) begin
          if (imem_resp_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else begin
          state_d = S_REQ;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_REQ;
      pc_q      <= RESET_PC;
      req_pc_q  <= RESET_PC;
      drop_q    <= 1'b0;
      inst_q    <= '0;
      inst_pc_q <= '0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      drop_q    <= drop_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      ferr_q    <= ferr_d;
    end
  end

`ifdef IFU_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q <= 1'b0;
    end else begin
      mis_q <= mis_d;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_24110026_ifu.sv
// Scoreboard bench for ysyx_24110026_ifu with a small imem responder.
// Build with IFU_MISALIGN_CHECK_EN to exercise the misalign trap.
module tb_ysyx_24110026_ifu;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } inst_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_err;
  logic        misalign_err;

  logic [31:0] exp_addr_q[$];
  inst_t       exp_inst_q[$];
  inst_t       mon_e;

  int n_pass = 0;
  int n_total = 0;
  int req_seen = 0;
  int inst_seen = 0;

  logic        mem_en = 1'b0;
  int          lat = 0;
  logic        r_hs;
  logic [31:0] r_addr;
  logic        pend = 1'b0;
  logic [31:0] pend_addr;
  int          pend_lat;

  always #5 clk = ~clk;

  ysyx_24110026_ifu #(
    .RESET_PC      (32'h8000_0000),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fetch_err      (fetch_err),
    .misalign_err   (misalign_err)
  );

  // Memory image: one real instruction at reset PC, a pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0010_0093;
    return a ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic flag(input string nm, input logic [31:0] act);
    n_total++;
    $display("FAIL %s: got %h expected none", nm, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop expected values on every handshake.
  always @(negedge clk) begin
    if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
      req_seen++;
      if (exp_addr_q.size() == 0) flag("unexpected_req", imem_req_addr);
      else chk("req_addr", imem_req_addr, exp_addr_q.pop_front());
    end
    if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
      inst_seen++;
      if (exp_inst_q.size() == 0) begin
        flag("unexpected_inst", inst);
      end else begin
        mon_e = exp_inst_q.pop_front();
        chk("inst", inst, mon_e.inst);
        chk("inst_pc", inst_pc, mon_e.pc);
      end
    end
  end

  // Responder: one response per accepted request, lat cycles late.
  always begin
    @(negedge clk);
    r_hs   = (imem_req_valid === 1'b1) && (imem_req_ready === 1'b1);
    r_addr = imem_req_addr;
    @(posedge clk);
    #1;
    imem_resp_valid = 1'b0;
    if (!mem_en) begin
      pend = 1'b0;
    end else begin
      if (r_hs) begin
        pend      = 1'b1;
        pend_addr = r_addr;
        pend_lat  = lat;
      end
      if (pend) begin
        if (pend_lat == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(pend_addr);
          pend            = 1'b0;
        end else begin
          pend_lat--;
        end
      end
    end
  end

  task automatic do_req(input logic [31:0] a);
    int seen0;
    int k;
    seen0 = req_seen;
    k = 0;
    exp_addr_q.push_back(a);
    imem_req_ready = 1'b1;
    while (req_seen == seen0 && k < 50) begin
      tick();
      k++;
    end
    imem_req_ready = 1'b0;
    if (req_seen == seen0) flag("req_wait_expired", a);
  endtask

  task automatic do_inst(input logic [31:0] d, input logic [31:0] p);
    int seen0;
    int k;
    seen0 = inst_seen;
    k = 0;
    exp_inst_q.push_back('{inst: d, pc: p});
    inst_ready = 1'b1;
    while (inst_seen == seen0 && k < 50) begin
      tick();
      k++;
    end
    inst_ready = 1'b0;
    if (inst_seen == seen0) flag("inst_wait_expired", p);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    inst_ready      = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    chk("rst_misalign", 32'(misalign_err), 32'd0);
    chk("rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("rst_req_addr", imem_req_addr, 32'h8000_0000);

    // First fetch, zero-latency memory, decoder stalls 5 cycles.
    mem_en = 1'b1;
    lat    = 0;
    do_req(32'h8000_0000);
    tick();
    chk("lat_inst_valid", 32'(inst_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("stall_inst", inst, 32'h0010_0093);
      chk("stall_pc", inst_pc, 32'h8000_0000);
      chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
      tick();
    end
    do_inst(32'h0010_0093, 32'h8000_0000);
    do_req(32'h8000_0004);
    do_inst(32'h8000_0017, 32'h8000_0004);

    // Redirect while waiting; the late response must be dropped.
    lat = 2;
    do_req(32'h8000_0008);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drop_no_inst", 32'(inst_valid), 32'd0);
      tick();
    end
    lat = 0;
    do_req(32'h8000_0100);
    do_inst(32'h8000_0113, 32'h8000_0100);

    // Redirect to top of memory, then sequential wrap to zero.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    do_req(32'hFFFF_FFFC);
    do_inst(32'hFFFF_FFEF, 32'hFFFF_FFFC);
    do_req(32'h0000_0000);
    do_inst(32'h0000_0013, 32'h0000_0000);

    // Redirect in S_OUT without decoder accept: valid drops.
    do_req(32'h0000_0004);
    tick();
    chk("out_inst_valid", 32'(inst_valid), 32'd1);
    chk("out_inst", inst, 32'h0000_0017);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    chk("out_redir_valid", 32'(inst_valid), 32'd0);
    chk("out_redir_req", 32'(imem_req_valid), 32'd1);
    chk("out_redir_addr", imem_req_addr, 32'h8000_0200);

    // Misaligned redirect target.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
    chk("mis_pulse", 32'(misalign_err), 32'd1);
    chk("mis_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    chk("mis_pulse_end", 32'(misalign_err), 32'd0);
    chk("mis_err_req", 32'(imem_req_valid), 32'd0);
    chk("mis_err_inst", 32'(inst_valid), 32'd0);
`else
    chk("mis_tied", 32'(misalign_err), 32'd0);
    chk("mis_req_addr", imem_req_addr, 32'h8000_0100);
`endif
    do_reset();

    // Reset with a response still in flight: it must be ignored.
    lat = 2;
    do_req(32'h8000_0000);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("rstmid_no_inst", 32'(inst_valid), 32'd0);
      chk("rstmid_addr", imem_req_addr, 32'h8000_0000);
      tick();
    end

    // Timeout: no response ever arrives.
    mem_en = 1'b0;
    do_req(32'h8000_0000);
    repeat (15) tick();
    chk("tmo_before", 32'(fetch_err), 32'd0);
    tick();
    chk("tmo_flag", 32'(fetch_err), 32'd1);
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    for (int i = 0; i < 6; i++) begin
      chk("err_no_req", 32'(imem_req_valid), 32'd0);
      chk("err_sticky", 32'(fetch_err), 32'd1);
      tick();
    end
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    do_reset();
    chk("post_rst_err", 32'(fetch_err), 32'd0);
    chk("post_rst_req", 32'(imem_req_valid), 32'd1);
    chk("post_rst_addr", imem_req_addr, 32'h8000_0000);

    chk("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
    chk("inst_q_empty", 32'(exp_inst_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
